// File: rtl/usb_host_arbiter.sv
// Fixed-priority PHY transmit arbiter: six sources onto one registered UTMI/ULPI TX data/valid pair.
// Optional status outputs (arb_grant, arb_conflict) are enabled by defining USB_HOST_ARB_STATUS_EN.
module usb_host_arbiter #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] reset_tx_data,
    input  logic              reset_tx_valid,
    input  logic              reset_active,
    input  logic [DATA_W-1:0] enum_tx_data,
    input  logic              enum_tx_valid,
    input  logic              enum_active,
    input  logic [DATA_W-1:0] trans_tx_data,
    input  logic              trans_tx_valid,
    input  logic              trans_active,
    input  logic [DATA_W-1:0] sof_tx_data,
    input  logic              sof_tx_valid,
    input  logic              sof_active,
    input  logic [DATA_W-1:0] token_tx_data,
    input  logic              token_tx_valid,
    input  logic              token_active,
    input  logic [DATA_W-1:0] protocol_tx_data,
    input  logic              protocol_tx_valid,
    input  logic              protocol_active,
`ifdef USB_HOST_ARB_STATUS_EN
    output logic [2:0]        arb_grant,
    output logic              arb_conflict,
`endif
    output logic [DATA_W-1:0] phy_tx_data,
    output logic              phy_tx_valid
);

    logic [DATA_W-1:0] data_d, data_q;
    logic              valid_d, valid_q;

    // Selection looks only at *_active; a granted source with valid low still drives its data.
    always_comb begin
        data_d  = '0;
        valid_d = 1'b0;
        if (reset_active) begin
            data_d  = reset_tx_data;
            valid_d = reset_tx_valid;
        end else if (enum_active) begin
            data_d  = enum_tx_data;
            valid_d = enum_tx_valid;
        end else if (trans_active) begin
            data_d  = trans_tx_data;
            valid_d = trans_tx_valid;
        end else if (sof_active) begin
            data_d  = sof_tx_data;
            valid_d = sof_tx_valid;
        end else if (token_active) begin
            data_d  = token_tx_data;
            valid_d = token_tx_valid;
        end else if (protocol_active) begin
            data_d  = protocol_tx_data;
            valid_d = protocol_tx_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign phy_tx_data  = data_q;
    assign phy_tx_valid = valid_q;

`ifdef USB_HOST_ARB_STATUS_EN
    localparam logic [2:0] GrantIdle = 3'd7;

    logic [2:0] grant_d, grant_q;
    logic       conflict_d, conflict_q;
    logic [5:0] active_vec;

    assign active_vec = {protocol_active, token_active, sof_active,
                         trans_active, enum_active, reset_active};

    always_comb begin
        grant_d = GrantIdle;
        if (reset_active)         grant_d = 3'd0;
        else if (enum_active)     grant_d = 3'd1;
        else if (trans_active)    grant_d = 3'd2;
        else if (sof_active)      grant_d = 3'd3;
        else if (token_active)    grant_d = 3'd4;
        else if (protocol_active) grant_d = 3'd5;
        // More than one bit set: clear the lowest set bit and see if anything remains.
        conflict_d = |(active_vec & (active_vec - 6'd1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q    <= GrantIdle;
            conflict_q <= 1'b0;
        end else begin
            grant_q    <= grant_d;
            conflict_q <= conflict_d;
        end
    end

    assign arb_grant    = grant_q;
    assign arb_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_usb_host_arbiter.sv
// Directed self-checking bench for usb_host_arbiter; status checks compile in with USB_HOST_ARB_STATUS_EN.
module tb_usb_host_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] reset_tx_data, enum_tx_data, trans_tx_data;
    logic [7:0] sof_tx_data, token_tx_data, protocol_tx_data;
    logic       reset_tx_valid, enum_tx_valid, trans_tx_valid;
    logic       sof_tx_valid, token_tx_valid, protocol_tx_valid;
    logic       reset_active, enum_active, trans_active;
    logic       sof_active, token_active, protocol_active;
    logic [7:0] phy_tx_data;
    logic       phy_tx_valid;
`ifdef USB_HOST_ARB_STATUS_EN
    logic [2:0] arb_grant;
    logic       arb_conflict;
`endif

    int vectors;
    int miscompares;

    usb_host_arbiter #(.DATA_W(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .reset_tx_data     (reset_tx_data),
        .reset_tx_valid    (reset_tx_valid),
        .reset_active      (reset_active),
        .enum_tx_data      (enum_tx_data),
        .enum_tx_valid     (enum_tx_valid),
        .enum_active       (enum_active),
        .trans_tx_data     (trans_tx_data),
        .trans_tx_valid    (trans_tx_valid),
        .trans_active      (trans_active),
        .sof_tx_data       (sof_tx_data),
        .sof_tx_valid      (sof_tx_valid),
        .sof_active        (sof_active),
        .token_tx_data     (token_tx_data),
        .token_tx_valid    (token_tx_valid),
        .token_active      (token_active),
        .protocol_tx_data  (protocol_tx_data),
        .protocol_tx_valid (protocol_tx_valid),
        .protocol_active   (protocol_active),
`ifdef USB_HOST_ARB_STATUS_EN
        .arb_grant         (arb_grant),
        .arb_conflict      (arb_conflict),
`endif
        .phy_tx_data       (phy_tx_data),
        .phy_tx_valid      (phy_tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        reset_tx_data = 8'h00; enum_tx_data = 8'h00; trans_tx_data = 8'h00;
        sof_tx_data = 8'h00; token_tx_data = 8'h00; protocol_tx_data = 8'h00;
        reset_tx_valid = 1'b0; enum_tx_valid = 1'b0; trans_tx_valid = 1'b0;
        sof_tx_valid = 1'b0; token_tx_valid = 1'b0; protocol_tx_valid = 1'b0;
        reset_active = 1'b0; enum_active = 1'b0; trans_active = 1'b0;
        sof_active = 1'b0; token_active = 1'b0; protocol_active = 1'b0;
    endtask

    // Source index follows priority: 0=reset .. 5=protocol.
    task automatic set_src(input int idx, input logic act, input logic val, input logic [7:0] d);
        case (idx)
            0: begin reset_active = act; reset_tx_valid = val; reset_tx_data = d; end
            1: begin enum_active = act; enum_tx_valid = val; enum_tx_data = d; end
            2: begin trans_active = act; trans_tx_valid = val; trans_tx_data = d; end
            3: begin sof_active = act; sof_tx_valid = val; sof_tx_data = d; end
            4: begin token_active = act; token_tx_valid = val; token_tx_data = d; end
            default: begin protocol_active = act; protocol_tx_valid = val; protocol_tx_data = d; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) set_src(i, 1'b1, 1'b1, 8'hF0 + 8'(i));
        tick();
        vectors++;
        if ({phy_tx_valid, phy_tx_data} !== 9'h000) begin
            miscompares++;
            $display("FAIL reset_hold: got valid=%0b data=%02h want valid=0 data=00",
                     phy_tx_valid, phy_tx_data);
        end
`ifdef USB_HOST_ARB_STATUS_EN
        vectors++;
        if ({arb_grant, arb_conflict} !== {3'd7, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_status: got grant=%0d conflict=%0b want grant=7 conflict=0",
                     arb_grant, arb_conflict);
        end
`endif
        rst_n = 1'b1;
        clear_inputs();
        tick();
        vectors++;
        if ({phy_tx_valid, phy_tx_data} !== 9'h000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got valid=%0b data=%02h want valid=0 data=00",
                     phy_tx_valid, phy_tx_data);
        end
    endtask

    task automatic test_inactive_ignored();
        clear_inputs();
        for (int i = 0; i < 6; i++) set_src(i, 1'b0, 1'b1, 8'h5A);
        tick();
        vectors++;
        if ({phy_tx_valid, phy_tx_data} !== 9'h000) begin
            miscompares++;
            $display("FAIL inactive_ignored: got valid=%0b data=%02h want valid=0 data=00",
                     phy_tx_valid, phy_tx_data);
        end
    endtask

    task automatic test_priority_stack();
        logic [7:0] exp_data [3];
        exp_data[0] = 8'hAA; exp_data[1] = 8'hBB; exp_data[2] = 8'hCC;
        clear_inputs();
        for (int s = 0; s < 3; s++) begin
            set_src(5 - s, 1'b1, 1'b1, exp_data[s]);
            tick();
            vectors++;
            if ({phy_tx_valid, phy_tx_data} !== {1'b1, exp_data[s]}) begin
                miscompares++;
                $display("FAIL stack_%0d: got valid=%0b data=%02h want valid=1 data=%02h",
                         s, phy_tx_valid, phy_tx_data, exp_data[s]);
            end
        end
`ifdef USB_HOST_ARB_STATUS_EN
        vectors++;
        if ({arb_grant, arb_conflict} !== {3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL stack_status: got grant=%0d conflict=%0b want grant=3 conflict=1",
                     arb_grant, arb_conflict);
        end
`endif
    endtask

    task automatic test_all_active();
        clear_inputs();
        set_src(5, 1'b1, 1'b1, 8'hAA);
        set_src(4, 1'b1, 1'b1, 8'hBB);
        set_src(3, 1'b1, 1'b1, 8'hCC);
        set_src(2, 1'b1, 1'b1, 8'hDD);
        set_src(1, 1'b1, 1'b1, 8'hEE);
        set_src(0, 1'b1, 1'b1, 8'hFF);
        tick();
        vectors++;
        if ({phy_tx_valid, phy_tx_data} !== 9'h1FF) begin
            miscompares++;
            $display("FAIL all_active: got valid=%0b data=%02h want valid=1 data=ff",
                     phy_tx_valid, phy_tx_data);
        end
        set_src(0, 1'b0, 1'b1, 8'hFF);
        set_src(3, 1'b0, 1'b1, 8'hCC);
        set_src(4, 1'b0, 1'b1, 8'hBB);
        set_src(5, 1'b0, 1'b1, 8'hAA);
        tick();
        vectors++;
        if ({phy_tx_valid, phy_tx_data} !== 9'h1EE) begin
            miscompares++;
            $display("FAIL enum_trans: got valid=%0b data=%02h want valid=1 data=ee",
                     phy_tx_valid, phy_tx_data);
        end
    endtask

    task automatic test_valid_low();
        clear_inputs();
        set_src(5, 1'b1, 1'b0, 8'hAA);
        set_src(4, 1'b0, 1'b1, 8'hBB);
        tick();
        vectors++;
        if ({phy_tx_valid, phy_tx_data} !== 9'h0AA) begin
            miscompares++;
            $display("FAIL valid_low: got valid=%0b data=%02h want valid=0 data=aa",
                     phy_tx_valid, phy_tx_data);
        end
`ifdef USB_HOST_ARB_STATUS_EN
        vectors++;
        if ({arb_grant, arb_conflict} !== {3'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL valid_low_status: got grant=%0d conflict=%0b want grant=5 conflict=0",
                     arb_grant, arb_conflict);
        end
`endif
    endtask

    task automatic test_dynamic();
        int         src [5];
        logic       act [5];
        logic [7:0] dat [5];
        logic [7:0] exp_data [5];
        src[0] = 5; act[0] = 1'b1; dat[0] = 8'hAA; exp_data[0] = 8'hAA;
        src[1] = 2; act[1] = 1'b1; dat[1] = 8'hDD; exp_data[1] = 8'hDD;
        src[2] = 0; act[2] = 1'b1; dat[2] = 8'hFF; exp_data[2] = 8'hFF;
        src[3] = 0; act[3] = 1'b0; dat[3] = 8'hFF; exp_data[3] = 8'hDD;
        src[4] = 2; act[4] = 1'b0; dat[4] = 8'hDD; exp_data[4] = 8'hAA;
        clear_inputs();
        tick();
        for (int s = 0; s < 5; s++) begin
            set_src(src[s], act[s], 1'b1, dat[s]);
            // Previous winner must still be on the outputs until the next edge.
            if (s > 0) begin
                vectors++;
                if ({phy_tx_valid, phy_tx_data} !== {1'b1, exp_data[s-1]}) begin
                    miscompares++;
                    $display("FAIL dyn_hold_%0d: got valid=%0b data=%02h want valid=1 data=%02h",
                             s, phy_tx_valid, phy_tx_data, exp_data[s-1]);
                end
            end
            tick();
            vectors++;
            if ({phy_tx_valid, phy_tx_data} !== {1'b1, exp_data[s]}) begin
                miscompares++;
                $display("FAIL dyn_step_%0d: got valid=%0b data=%02h want valid=1 data=%02h",
                         s, phy_tx_valid, phy_tx_data, exp_data[s]);
            end
        end
    endtask

    task automatic test_each_source();
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            set_src(i, 1'b1, 1'b1, 8'(i + 1));
            tick();
            vectors++;
            if ({phy_tx_valid, phy_tx_data} !== {1'b1, 8'(i + 1)}) begin
                miscompares++;
                $display("FAIL alone_%0d: got valid=%0b data=%02h want valid=1 data=%02h",
                         i, phy_tx_valid, phy_tx_data, 8'(i + 1));
            end
`ifdef USB_HOST_ARB_STATUS_EN
            vectors++;
            if ({arb_grant, arb_conflict} !== {3'(i), 1'b0}) begin
                miscompares++;
                $display("FAIL alone_status_%0d: got grant=%0d conflict=%0b want grant=%0d conflict=0",
                         i, arb_grant, arb_conflict, i);
            end
`endif
        end
        // Mid-stream reset with protocol (0x06) still active and valid.
        rst_n = 1'b0;
        tick();
        vectors++;
        if ({phy_tx_valid, phy_tx_data} !== 9'h000) begin
            miscompares++;
            $display("FAIL mid_reset: got valid=%0b data=%02h want valid=0 data=00",
                     phy_tx_valid, phy_tx_data);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({phy_tx_valid, phy_tx_data} !== 9'h106) begin
            miscompares++;
            $display("FAIL resume: got valid=%0b data=%02h want valid=1 data=06",
                     phy_tx_valid, phy_tx_data);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_inputs();
        test_reset();
        test_inactive_ignored();
        test_priority_stack();
        test_all_active();
        test_valid_low();
        test_dynamic();
        test_each_source();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
